// File: rtl/output_deskewer.sv
// Realigns the diagonally skewed column outputs of a systolic array into whole rows,
// collects one MATRIX_SIZE-row frame and drains it one row per valid/ready handshake.
module output_deskewer #(
  parameter int unsigned MATRIX_SIZE = 2,
  parameter int unsigned DATA_SIZE   = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] sum_in,
  input  logic                                  sum_valid,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_out,
  output logic [$clog2(MATRIX_SIZE)-1:0]        row_idx,
  output logic                                  row_valid,
  input  logic                                  row_ready,
  output logic                                  done,
  output logic                                  overflow
);
  localparam int unsigned IdxW = $clog2(MATRIX_SIZE);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(MATRIX_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

  state_e                                state_q, state_d;
  logic [IdxW-1:0]                       wr_cnt_q, wr_cnt_d;
  logic [IdxW-1:0]                       rd_cnt_q, rd_cnt_d;
  logic                                  done_q, done_d;
  logic                                  overflow_q, overflow_d;
  logic [MATRIX_SIZE-2:0]                valid_pipe_q;
  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] aligned_row;
  logic                                  aligned_valid;
  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] buffer_q [MATRIX_SIZE];
  logic                                  buf_we;
  logic [IdxW-1:0]                       buf_waddr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_pipe_q <= '0;
    end else begin
      valid_pipe_q[0] <= sum_valid;
      for (int k = 1; k < int'(MATRIX_SIZE) - 1; k++) valid_pipe_q[k] <= valid_pipe_q[k-1];
    end
  end

  assign aligned_valid = valid_pipe_q[MATRIX_SIZE-2];

  // Earlier columns wait longer so every element of a row lines up with the last column.
  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    localparam int unsigned Depth = MATRIX_SIZE - 1 - j;
    if (Depth == 0) begin : g_pass
      assign aligned_row[j] = sum_in[j];
    end else begin : g_dly
      logic [DATA_SIZE-1:0] pipe_q [Depth];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < int'(Depth); k++) pipe_q[k] <= '0;
        end else begin
          pipe_q[0] <= sum_in[j];
          for (int k = 1; k < int'(Depth); k++) pipe_q[k] <= pipe_q[k-1];
        end
      end
      assign aligned_row[j] = pipe_q[Depth-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(MATRIX_SIZE); r++) buffer_q[r] <= '0;
    end else if (buf_we) begin
      buffer_q[buf_waddr] <= aligned_row;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    buf_we     = 1'b0;
    buf_waddr  = wr_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (aligned_valid) begin
          buf_we    = 1'b1;
          buf_waddr = '0;
          wr_cnt_d  = IdxW'(1);
          state_d   = StCollect;
        end
      end
      StCollect: begin
        if (aligned_valid) begin
          buf_we = 1'b1;
          if (wr_cnt_q == LastIdx) begin
            state_d  = StDrain;
            rd_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + IdxW'(1);
          end
        end
      end
      StDrain: begin
        // The buffer is busy; a newly aligned row has nowhere to go.
        if (aligned_valid) overflow_d = 1'b1;
        if (row_ready) begin
          if (rd_cnt_q == LastIdx) begin
            state_d  = StIdle;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            done_d   = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    row_valid = (state_q == StDrain);
    row_out   = row_valid ? buffer_q[rd_cnt_q] : '0;
    row_idx   = row_valid ? rd_cnt_q : '0;
  end

  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_output_deskewer.sv
// Drives a 2x2 and a 4x4 deskewer with the same skewed stream and compares both against
// a frame-level model (collect N rows, then drain them, dropping rows that arrive meanwhile).
module tb_output_deskewer;
  localparam int NMAX = 64;
  typedef logic [3:0][31:0] row_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sum_valid, row_ready;
  logic [3:0][31:0] sum_in4;
  logic [1:0][31:0] sum_in2;
  logic [1:0][31:0] row_out2;
  logic [0:0]       row_idx2;
  logic             row_valid2, done2, overflow2;
  logic [3:0][31:0] row_out4;
  logic [1:0]       row_idx4;
  logic             row_valid4, done4, overflow4;

  assign sum_in2 = sum_in4[1:0];

  output_deskewer #(.MATRIX_SIZE(2), .DATA_SIZE(32)) u_dut2 (
    .clk(clk), .reset(reset), .sum_in(sum_in2), .sum_valid(sum_valid), .row_out(row_out2),
    .row_idx(row_idx2), .row_valid(row_valid2), .row_ready(row_ready), .done(done2),
    .overflow(overflow2)
  );

  output_deskewer #(.MATRIX_SIZE(4), .DATA_SIZE(32)) u_dut4 (
    .clk(clk), .reset(reset), .sum_in(sum_in4), .sum_valid(sum_valid), .row_out(row_out4),
    .row_idx(row_idx4), .row_valid(row_valid4), .row_ready(row_ready), .done(done4),
    .overflow(overflow4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stimulus schedule: a row starts (column 0) at cycle t when sv_at[t] is set.
  bit   sv_at   [NMAX];
  row_t data_at [NMAX];
  bit   rdy_at  [NMAX];

  // Frame model per DUT (index 0: size 2, index 1: size 4).
  row_t fr [2][4];
  int   fr_n [2];
  int   drain_left [2];
  bit   done_e [2];
  bit   ovf_e [2];

  logic         obs_v [2][NMAX];
  logic         obs_d [2][NMAX];
  logic         obs_o [2][NMAX];
  logic [1:0]   obs_i [2][NMAX];
  logic [127:0] obs_r [2][NMAX];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, want);
    end
  endtask

  function automatic row_t mk(input int unsigned a, input int unsigned b,
                              input int unsigned c, input int unsigned d);
    row_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      fr_n[d] = 0; drain_left[d] = 0; done_e[d] = 1'b0; ovf_e[d] = 1'b0;
    end
  endfunction

  function automatic void model_step(input int d, input int m, input bit rdy, input bit arr,
                                     input row_t arow);
    bit draining;
    draining  = drain_left[d] > 0;
    done_e[d] = draining && rdy && (drain_left[d] == 1);
    if (draining && rdy) drain_left[d]--;
    if (arr) begin
      if (draining) begin
        ovf_e[d] = 1'b1;
      end else begin
        fr[d][fr_n[d]] = arow;
        fr_n[d]++;
        if (fr_n[d] == m) begin
          drain_left[d] = m;
          fr_n[d] = 0;
        end
      end
    end
  endfunction

  task automatic clear_sched();
    for (int c = 0; c < NMAX; c++) begin
      sv_at[c] = 1'b0; data_at[c] = '0; rdy_at[c] = 1'b1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " m2 row_out"}, 128'(row_out2), '0);
    chk({tag, " m2 row_idx"}, 128'(row_idx2), '0);
    chk({tag, " m2 row_valid"}, 128'(row_valid2), '0);
    chk({tag, " m2 done"}, 128'(done2), '0);
    chk({tag, " m2 overflow"}, 128'(overflow2), '0);
    chk({tag, " m4 row_out"}, 128'(row_out4), '0);
    chk({tag, " m4 row_idx"}, 128'(row_idx4), '0);
    chk({tag, " m4 row_valid"}, 128'(row_valid4), '0);
    chk({tag, " m4 done"}, 128'(done4), '0);
    chk({tag, " m4 overflow"}, 128'(overflow4), '0);
  endtask

  task automatic do_reset();
    reset = 1'b1; sum_valid = 1'b0; row_ready = 1'b0; sum_in4 = '0;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic drive(input int c);
    sum_valid = sv_at[c];
    row_ready = rdy_at[c];
    for (int j = 0; j < 4; j++) begin
      if (c - j >= 0 && sv_at[c-j]) sum_in4[j] = data_at[c-j][j];
      else sum_in4[j] = $urandom;
    end
  endtask

  task automatic record(input int c);
    obs_v[0][c] = row_valid2; obs_d[0][c] = done2; obs_o[0][c] = overflow2;
    obs_i[0][c] = {1'b0, row_idx2}; obs_r[0][c] = 128'(row_out2);
    obs_v[1][c] = row_valid4; obs_d[1][c] = done4; obs_o[1][c] = overflow4;
    obs_i[1][c] = row_idx4; obs_r[1][c] = 128'(row_out4);
  endtask

  task automatic check_dut(input int d, input int m, input string tag, input int c);
    bit           v;
    int           idx;
    logic [127:0] er;
    string        p;
    v   = drain_left[d] > 0;
    idx = v ? m - drain_left[d] : 0;
    er  = v ? fr[d][idx] : '0;
    if (m == 2) er[127:64] = '0;
    p = $sformatf("%s m%0d c%0d", tag, m, c);
    chk({p, " row_valid"}, 128'(obs_v[d][c]), 128'(v));
    chk({p, " row_out"}, obs_r[d][c], er);
    chk({p, " row_idx"}, 128'(obs_i[d][c]), 128'(idx));
    chk({p, " done"}, 128'(obs_d[d][c]), 128'(done_e[d]));
    chk({p, " overflow"}, 128'(obs_o[d][c]), 128'(ovf_e[d]));
  endtask

  task automatic run_sched(input string tag, input int ncyc, input bit with_reset);
    int   m, src;
    bit   arr;
    row_t arow;
    if (with_reset) do_reset();
    else model_clear();
    for (int c = 0; c < ncyc; c++) begin
      drive(c);
      @(negedge clk);
      record(c);
      check_dut(0, 2, tag, c);
      check_dut(1, 4, tag, c);
      for (int d = 0; d < 2; d++) begin
        m    = (d == 0) ? 2 : 4;
        src  = c - (m - 1);
        arr  = 1'b0;
        arow = '0;
        if (src >= 0) begin
          arr  = sv_at[src];
          arow = data_at[src];
        end
        model_step(d, m, rdy_at[c], arr, arow);
      end
      @(posedge clk);
      #1;
    end
    sum_valid = 1'b0;
  endtask

  initial begin
    sum_valid = 1'b0; row_ready = 1'b0; sum_in4 = '0;

    // Basic two-row frame, consumer always ready.
    clear_sched();
    sv_at[0] = 1'b1; data_at[0] = mk(5, 6, 105, 106);
    sv_at[1] = 1'b1; data_at[1] = mk(7, 8, 107, 108);
    run_sched("basic", 10, 1'b1);
    chk("basic c2 valid", 128'(obs_v[0][2]), 0);
    chk("basic c3 valid", 128'(obs_v[0][3]), 1);
    chk("basic c3 row", obs_r[0][3], mk(5, 6, 0, 0));
    chk("basic c3 idx", 128'(obs_i[0][3]), 0);
    chk("basic c4 row", obs_r[0][4], mk(7, 8, 0, 0));
    chk("basic c4 idx", 128'(obs_i[0][4]), 1);
    chk("basic c4 done", 128'(obs_d[0][4]), 0);
    chk("basic c5 done", 128'(obs_d[0][5]), 1);
    chk("basic c5 valid", 128'(obs_v[0][5]), 0);

    // Backpressure: consumer stalls during cycles 3..6.
    for (int c = 3; c <= 6; c++) rdy_at[c] = 1'b0;
    run_sched("bp", 14, 1'b1);
    for (int c = 3; c <= 7; c++) begin
      chk($sformatf("bp c%0d held row", c), obs_r[0][c], mk(5, 6, 0, 0));
      chk($sformatf("bp c%0d held idx", c), 128'(obs_i[0][c]), 0);
    end
    chk("bp c8 row", obs_r[0][8], mk(7, 8, 0, 0));
    chk("bp c8 done", 128'(obs_d[0][8]), 0);
    chk("bp c9 done", 128'(obs_d[0][9]), 1);

    // Gapped rows.
    clear_sched();
    sv_at[0] = 1'b1; data_at[0] = mk(5, 6, 105, 106);
    sv_at[4] = 1'b1; data_at[4] = mk(7, 8, 107, 108);
    run_sched("gap", 12, 1'b1);
    chk("gap c5 valid", 128'(obs_v[0][5]), 0);
    chk("gap c6 valid", 128'(obs_v[0][6]), 1);
    chk("gap c6 row", obs_r[0][6], mk(5, 6, 0, 0));
    chk("gap c7 row", obs_r[0][7], mk(7, 8, 0, 0));
    chk("gap c8 done", 128'(obs_d[0][8]), 1);

    // Third row lands while draining.
    sv_at[4] = 1'b0; data_at[4] = '0;
    sv_at[1] = 1'b1; data_at[1] = mk(7, 8, 107, 108);
    sv_at[2] = 1'b1; data_at[2] = mk(9, 10, 109, 110);
    run_sched("ovf", 12, 1'b1);
    chk("ovf c3 overflow", 128'(obs_o[0][3]), 0);
    chk("ovf c4 overflow", 128'(obs_o[0][4]), 1);
    chk("ovf c11 overflow", 128'(obs_o[0][11]), 1);
    chk("ovf c3 row", obs_r[0][3], mk(5, 6, 0, 0));
    chk("ovf c4 row", obs_r[0][4], mk(7, 8, 0, 0));
    chk("ovf m4 c11 overflow", 128'(obs_o[1][11]), 0);

    // Row aligned in the done cycle starts the next frame.
    clear_sched();
    sv_at[0] = 1'b1; data_at[0] = mk(5, 6, 105, 106);
    sv_at[1] = 1'b1; data_at[1] = mk(7, 8, 107, 108);
    sv_at[4] = 1'b1; data_at[4] = mk(11, 12, 111, 112);
    sv_at[5] = 1'b1; data_at[5] = mk(13, 14, 113, 114);
    run_sched("donecyc", 14, 1'b1);
    chk("donecyc c7 row", obs_r[0][7], mk(11, 12, 0, 0));
    chk("donecyc c8 row", obs_r[0][8], mk(13, 14, 0, 0));
    chk("donecyc c9 done", 128'(obs_d[0][9]), 1);
    chk("donecyc c13 overflow", 128'(obs_o[0][13]), 0);

    // Asynchronous reset while a row is presented.
    clear_sched();
    sv_at[0] = 1'b1; data_at[0] = mk(5, 6, 105, 106);
    sv_at[1] = 1'b1; data_at[1] = mk(7, 8, 107, 108);
    sv_at[2] = 1'b1; data_at[2] = mk(9, 10, 109, 110);
    run_sched("rstdrain", 4, 1'b1);
    chk("rstdrain pre valid", 128'(row_valid2), 1);
    #1 reset = 1'b1;
    #1;
    chk_zero("rstdrain async");
    @(posedge clk);
    #1 reset = 1'b0;
    sum_valid = 1'b0; row_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rstdrain post%0d m2 done", c), 128'(done2), 0);
      chk($sformatf("rstdrain post%0d m2 valid", c), 128'(row_valid2), 0);
      chk($sformatf("rstdrain post%0d m4 valid", c), 128'(row_valid4), 0);
      @(posedge clk);
      #1;
    end
    clear_sched();
    sv_at[0] = 1'b1; data_at[0] = mk(21, 22, 121, 122);
    sv_at[1] = 1'b1; data_at[1] = mk(23, 24, 123, 124);
    run_sched("fresh", 10, 1'b0);
    chk("fresh c3 row", obs_r[0][3], mk(21, 22, 0, 0));
    chk("fresh c4 row", obs_r[0][4], mk(23, 24, 0, 0));
    chk("fresh c5 done", 128'(obs_d[0][5]), 1);
    chk("fresh c9 overflow", 128'(obs_o[0][9]), 0);

    // Four-row frame on the 4x4 instance.
    clear_sched();
    for (int r = 0; r < 4; r++) begin
      sv_at[r]   = 1'b1;
      data_at[r] = mk(4 * r + 1, 4 * r + 2, 4 * r + 3, 4 * r + 4);
    end
    run_sched("m4", 14, 1'b1);
    chk("m4 c6 valid", 128'(obs_v[1][6]), 0);
    chk("m4 c7 valid", 128'(obs_v[1][7]), 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("m4 row%0d data", k), obs_r[1][7+k],
          mk(4 * k + 1, 4 * k + 2, 4 * k + 3, 4 * k + 4));
      chk($sformatf("m4 row%0d idx", k), 128'(obs_i[1][7+k]), 128'(k));
    end
    chk("m4 c11 done", 128'(obs_d[1][11]), 1);

    // Random traffic and backpressure.
    for (int it = 0; it < 4; it++) begin
      clear_sched();
      for (int c = 0; c < 30; c++) begin
        sv_at[c]   = ($urandom_range(0, 2) == 0);
        data_at[c] = {$urandom, $urandom, $urandom, $urandom};
      end
      for (int c = 0; c < NMAX; c++) rdy_at[c] = ($urandom_range(0, 3) != 0);
      run_sched($sformatf("rand%0d", it), 60, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_deskewer.md
# output_deskewer

Receive-side counterpart of the input skewing stage. The block takes the diagonally skewed partial-sum columns leaving the systolic array (column j lags column 0 by j cycles), realigns each result row, and collects MATRIX_SIZE rows into a buffer. It then drains the buffer one row per valid/ready handshake to the downstream consumer and pulses `done` after the last row.

## Interface
- `MATRIX_SIZE`, default 2, array dimension (rows and columns); must be ≥2.
- `DATA_SIZE`, default 32, width of one result element.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `sum_in`  input  [DATA_SIZE-1:0] x MATRIX_SIZE  skewed column outputs from the array.
- `sum_valid`  input  1  column 0 carries a valid row element this cycle; column j carries the same row's element j cycles later.
- `row_out`  output  [DATA_SIZE-1:0] x MATRIX_SIZE  aligned result row being presented.
- `row_idx`  output  $clog2(MATRIX_SIZE)  index of the row on `row_out`.
- `row_valid`  output  1  `row_out`/`row_idx` valid.
- `row_ready`  input  1  consumer accepts the row when high with `row_valid`.
- `done`  output  1  one-cycle pulse after the last row is accepted.
- `overflow`  output  1  sticky; an aligned row arrived while draining and was dropped.

## Operation
- Column j passes through a free-running delay line of MATRIX_SIZE-1-j registers; column MATRIX_SIZE-1 has no delay. Delay lines shift every cycle and are never gated.
- `sum_valid` passes through a MATRIX_SIZE-1 stage delay line. Its output, `aligned_valid`, is high in the same cycle as the fully aligned row.
- FSM states:
  - IDLE
    - `aligned_valid` → write the aligned row into buffer[0], set `wr_cnt`=1, go to COLLECT.
  - COLLECT
    - `aligned_valid` → write buffer[`wr_cnt`] and increment `wr_cnt`.
    - When the write fills the last slot (`wr_cnt` was MATRIX_SIZE-1) → go to DRAIN and set `rd_cnt`=0.
    - Gaps between rows are allowed and have no timeout.
  - DRAIN
    - Hold `row_valid`=1, `row_out`=buffer[`rd_cnt`], `row_idx`=`rd_cnt`.
    - On `row_valid && row_ready` → increment `rd_cnt`.
    - On acceptance of row MATRIX_SIZE-1 → go to IDLE, pulse `done`, and set `rd_cnt`=0 and `wr_cnt`=0.
- `aligned_valid` in DRAIN → row dropped, `overflow` set. The buffer is unchanged and `overflow` stays set until reset.
- `row_out` holds stable while `row_valid && !row_ready`.
- Data is passed through verbatim with no arithmetic. `wr_cnt` and `rd_cnt` never exceed MATRIX_SIZE-1; they wrap to 0 only via the state transitions above.

## Timing
- Reset values:
  - `row_out` = 0, `row_idx` = 0, `row_valid` = 0, `done` = 0, `overflow` = 0.
  - State IDLE, counters 0, all delay-line and buffer registers 0.
- `sum_valid` at cycle t for row r:
  - column-j element sampled at t+j;
  - `aligned_valid` at t+MATRIX_SIZE-1;
  - row written into the buffer at the edge ending that cycle.
- Last row (`sum_valid` at t_last): `row_valid` first high at cycle t_last+MATRIX_SIZE.
- Each accepted handshake advances the row at the next edge. With `row_ready` held high, the MATRIX_SIZE rows drain in MATRIX_SIZE consecutive cycles.
- `done` is high in the cycle after the final handshake. In that cycle `row_valid`=0 and the state is IDLE.
- If `aligned_valid` is high in the `done` cycle, that row is accepted into buffer[0] because the state is already IDLE.
- Asynchronous reset mid-COLLECT or mid-DRAIN:
  - immediately drops `row_valid`;
  - clears the delay lines, which discards in-flight data;
  - returns the FSM to IDLE.
  - `done` does not pulse.

## Test plan
- Basic, MATRIX_SIZE=2, `row_ready`=1:
  - stimulus: `sum_valid` at cycles 0,1; column 0 = 5,7 at cycles 0,1; column 1 = 6,8 at cycles 1,2;
  - required: `row_valid` at cycles 3,4 with {5,6} idx0 then {7,8} idx1; `done` at cycle 5.
- Backpressure: same stimulus with `row_ready`=0 for cycles 3–6 → row {5,6} idx0 held stable; advances at the first ready cycle; `done` exactly one cycle after the second handshake.
- Gapped input: `sum_valid` at cycles 0 and 4 → rows stay correctly paired ({5,6}, {7,8}); `row_valid` first at cycle 6.
- Overflow: a third `sum_valid` whose aligned row arrives while in DRAIN → `overflow`=1 and stays 1; drained rows match the first two rows.
- Reset mid-DRAIN: assert `reset` while `row_valid`=1 → all outputs 0 immediately with no `done`. A fresh two-row frame afterwards drains correctly with `overflow`=0.
- MATRIX_SIZE=4: four rows with distinct values per element → rows emitted in order idx0..3 with correct alignment; `row_valid` first at t_last+4.
